sram_bank_arb: RTL
==================

// Module: sram_bank_arb
// PURPOSE
//  Parametrised multi-port, multi-bank SRAM subsystem. NUM_PORTS OBI ports share NUM_BANKS
//  single-rw word banks, with per-bank round-robin arbitration and 1-cycle read latency.
//  Out-of-range or forbidden requests get a decoded error response. Sits between the core
//  I/D OBI muxes and on-chip SRAM; supersedes fixed 2-port/6-bank wrappers.
// PARAMETERS
//  NUM_PORTS     2              number of OBI requester ports (>=1)
//  NUM_BANKS     6              number of banks (any value >=1, need not be a power of 2)
//  BANK_WORDS    512            32-bit words per bank (power of 2)
//  BASE_ADDR     32'h8000_0000  byte address of bank 0, word 0
//  RO_PORT_MASK  'b10           bit p=1: port p is read-only (a write is an error)
//  ERR_RDATA     32'hDEAD_BEEF  rdata returned with an error response
// PORTS
//  clk_i     in   1              clock
//  rst_ni    in   1              reset, asynchronous, active-low
//  req_i     in   NUM_PORTS      OBI request, per port
//  gnt_o     out  NUM_PORTS      OBI grant, combinational, same cycle as accepted req
//  addr_i    in   NUM_PORTS*32   byte address, port p at [32p+:32]
//  we_i      in   NUM_PORTS      1 = write
//  be_i      in   NUM_PORTS*4    byte enables
//  wdata_i   in   NUM_PORTS*32   write data
//  rvalid_o  out  NUM_PORTS      response valid, 1 cycle after gnt
//  rdata_o   out  NUM_PORTS*32   read data, valid with rvalid_o
//  err_o     out  NUM_PORTS      error response flag, valid with rvalid_o
//  illegal_memory_o out 1        1-cycle pulse, coincident with any error rvalid
// BEHAVIOUR
//  - Decode: off = addr - BASE_ADDR. Legal iff addr >= BASE_ADDR,
//    off < NUM_BANKS*BANK_WORDS*4 (end exclusive), and not (we && RO_PORT_MASK[p]).
//    bank = off / (BANK_WORDS*4), word = off[log2(BANK_WORDS)+1:2]; addr[1:0] ignored.
//  - Illegal req: granted in the same cycle unconditionally, no bank access. Next cycle:
//    rvalid=1, err=1, rdata=ERR_RDATA, illegal_memory_o=1.
//  - Legal req: each bank grants at most one port per cycle. Winner = first requesting port
//    at or after rr_ptr[bank], searching upward mod NUM_PORTS. On grant,
//    rr_ptr[bank] <= winner+1 mod NUM_PORTS. Losers see gnt=0 and must hold req/addr/we/
//    be/wdata stable until granted (OBI rule; the block does not queue).
//  - Requests to different banks in the same cycle are all granted.
//  - Read: rvalid/rdata 1 cycle after gnt, rdata from the bank/port captured at grant.
//    Write: byte-masked by be; rvalid 1 cycle after gnt, err=0, rdata=0.
//  - Read-after-write: a read granted the cycle after a write to the same word returns
//    the new data. Back-to-back grants to one port give back-to-back rvalids.
//  - Reset (rst_ni low, async): rvalid_o=0, err_o=0, illegal_memory_o=0, all rr_ptr=0,
//    in-flight responses discarded; gnt_o forced 0 while in reset. Memory not cleared.
//  - Bank storage: behavioural array, synchronous read/write, no read-during-write on one
//    bank (single rw port per bank; arbitration guarantees this).
// TESTING
//  1 rst_ni=0, req_i=2'b11 -> gnt_o=0, rvalid_o=0; release -> first legal req granted.
//  2 P0 write 0x8000_0010=0x1234_5678 be=4'hF; next cycle P1 read 0x8000_0010 -> gnt same
//    cycle; rvalid next cycle, rdata=0x1234_5678, err=0.
//  3 P0 write 0x8000_0010 be=4'b0010 data=0xAABB_CCDD; read back -> 0x1234_CC78.
//  4 P0 and P1 both hold reads to bank 2 (0x8000_1000) for 3 cycles -> gnt P0, P1, P0;
//    each rvalid exactly 1 cycle after its gnt; rr_ptr wraps correctly.
//  5 Same cycle: P0 reads bank 0, P1 reads bank 5 (0x8000_2FFC) -> both gnt; both rvalid next.
//  6 P0 read 0x8000_3000 (end) and 0x7FFF_FFFC; P1 write 0x8000_0000 -> each gnt, then
//    err=1, rdata=0xDEAD_BEEF, illegal_memory_o pulse; memory at 0x8000_0000 unchanged.

Source files
------------

// File: rtl/sram_bank_arb.sv
// Multi-port, multi-bank word SRAM with per-bank round-robin arbitration.
// One-cycle read latency; out-of-range or read-only-port writes get an error response.
module sram_bank_arb #(
   parameter int unsigned           NUM_PORTS    = 2,
   parameter int unsigned           NUM_BANKS    = 6,
   parameter int unsigned           BANK_WORDS   = 512,
   parameter logic [31:0]           BASE_ADDR    = 32'h8000_0000,
   parameter logic [NUM_PORTS-1:0]  RO_PORT_MASK = 'b10,
   parameter logic [31:0]           ERR_RDATA    = 32'hDEAD_BEEF
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [NUM_PORTS-1:0]      req_i,
   output logic [NUM_PORTS-1:0]      gnt_o,
   input  logic [NUM_PORTS*32-1:0]   addr_i,
   input  logic [NUM_PORTS-1:0]      we_i,
   input  logic [NUM_PORTS*4-1:0]    be_i,
   input  logic [NUM_PORTS*32-1:0]   wdata_i,
   output logic [NUM_PORTS-1:0]      rvalid_o,
   output logic [NUM_PORTS*32-1:0]   rdata_o,
   output logic [NUM_PORTS-1:0]      err_o,
   output logic                      illegal_memory_o
);

   localparam int unsigned WORD_W  = $clog2(BANK_WORDS);
   localparam int unsigned BANK_SH = WORD_W + 2;
   localparam int unsigned BANK_W  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
   localparam int unsigned PORT_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam logic [63:0] TOTAL_BYTES = 64'(NUM_BANKS) * 64'(BANK_WORDS) * 64'd4;

   logic [NUM_PORTS-1:0] legal;
   logic [BANK_W-1:0]    p_bank [NUM_PORTS];
   logic [WORD_W-1:0]    p_word [NUM_PORTS];

   logic [PORT_W-1:0]    rr_q [NUM_BANKS];
   logic [PORT_W-1:0]    rr_d [NUM_BANKS];
   logic [NUM_BANKS-1:0] bank_go;
   logic [NUM_BANKS-1:0] bank_we;
   logic [WORD_W-1:0]    bank_word  [NUM_BANKS];
   logic [3:0]           bank_be    [NUM_BANKS];
   logic [31:0]          bank_wdata [NUM_BANKS];

   logic [31:0]          mem_q        [NUM_BANKS][BANK_WORDS];
   logic [31:0]          bank_rdata_q [NUM_BANKS];

   logic [NUM_PORTS-1:0] gnt;
   logic [NUM_PORTS-1:0] rvalid_d, rvalid_q;
   logic [NUM_PORTS-1:0] err_d, err_q;
   logic [NUM_PORTS-1:0] wr_d, wr_q;
   logic [BANK_W-1:0]    bsel_d [NUM_PORTS];
   logic [BANK_W-1:0]    bsel_q [NUM_PORTS];

   // The subtraction wraps below BASE_ADDR, so the lower bound is checked on the raw address.
   always_comb begin
      logic [31:0] a;
      logic [31:0] off;
      a     = '0;
      off   = '0;
      legal = '0;
      for (int p = 0; p < int'(NUM_PORTS); p++) begin
         a         = addr_i[32*p +: 32];
         off       = a - BASE_ADDR;
         legal[p]  = (a >= BASE_ADDR) && ({32'd0, off} < TOTAL_BYTES) &&
                     !(we_i[p] && RO_PORT_MASK[p]);
         p_bank[p] = BANK_W'(off >> BANK_SH);
         p_word[p] = off[WORD_W+1:2];
      end
   end

   always_comb begin
      int   idx;
      int   sel;
      logic found;
      idx     = 0;
      sel     = 0;
      found   = 1'b0;
      gnt     = '0;
      bank_go = '0;
      bank_we = '0;
      for (int b = 0; b < int'(NUM_BANKS); b++) begin
         rr_d[b]       = rr_q[b];
         bank_word[b]  = '0;
         bank_be[b]    = '0;
         bank_wdata[b] = '0;
      end
      for (int b = 0; b < int'(NUM_BANKS); b++) begin
         found = 1'b0;
         sel   = 0;
         for (int i = 0; i < int'(NUM_PORTS); i++) begin
            idx = int'(rr_q[b]) + i;
            if (idx >= int'(NUM_PORTS)) idx = idx - int'(NUM_PORTS);
            if (!found && req_i[idx] && legal[idx] && (p_bank[idx] == BANK_W'(b))) begin
               found = 1'b1;
               sel   = idx;
            end
         end
         if (found && rst_ni) begin
            gnt[sel]      = 1'b1;
            bank_go[b]    = 1'b1;
            bank_we[b]    = we_i[sel];
            bank_word[b]  = p_word[sel];
            bank_be[b]    = be_i[4*sel +: 4];
            bank_wdata[b] = wdata_i[32*sel +: 32];
            rr_d[b]       = (sel + 1 >= int'(NUM_PORTS)) ? '0 : PORT_W'(sel + 1);
         end
      end
      // Illegal requests never touch a bank, so they are accepted without arbitration.
      for (int p = 0; p < int'(NUM_PORTS); p++) begin
         if (rst_ni && req_i[p] && !legal[p]) gnt[p] = 1'b1;
      end
   end

   assign gnt_o = gnt;

   always_comb begin
      rvalid_d = gnt;
      err_d    = gnt & ~legal;
      wr_d     = we_i;
      for (int p = 0; p < int'(NUM_PORTS); p++) bsel_d[p] = p_bank[p];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rvalid_q <= '0;
         err_q    <= '0;
         wr_q     <= '0;
         for (int p = 0; p < int'(NUM_PORTS); p++) bsel_q[p] <= '0;
         for (int b = 0; b < int'(NUM_BANKS); b++) rr_q[b] <= '0;
      end else begin
         rvalid_q <= rvalid_d;
         err_q    <= err_d;
         wr_q     <= wr_d;
         for (int p = 0; p < int'(NUM_PORTS); p++) bsel_q[p] <= bsel_d[p];
         for (int b = 0; b < int'(NUM_BANKS); b++) rr_q[b] <= rr_d[b];
      end
   end

   // Storage is not reset; at most one port reaches a bank per cycle.
   always_ff @(posedge clk_i) begin
      for (int b = 0; b < int'(NUM_BANKS); b++) begin
         if (bank_go[b]) begin
            if (bank_we[b]) begin
               for (int k = 0; k < 4; k++) begin
                  if (bank_be[b][k]) mem_q[b][bank_word[b]][8*k +: 8] <= bank_wdata[b][8*k +: 8];
               end
            end else begin
               bank_rdata_q[b] <= mem_q[b][bank_word[b]];
            end
         end
      end
   end

   always_comb begin
      rdata_o = '0;
      for (int p = 0; p < int'(NUM_PORTS); p++) begin
         if (rvalid_q[p]) begin
            if (err_q[p])      rdata_o[32*p +: 32] = ERR_RDATA;
            else if (!wr_q[p]) rdata_o[32*p +: 32] = bank_rdata_q[bsel_q[p]];
         end
      end
   end

   assign rvalid_o         = rvalid_q;
   assign err_o            = err_q;
   assign illegal_memory_o = |err_q;

endmodule
